// File: rtl/irq_src_conditioner.sv
// irq_src_conditioner: per-source invert, synchronize, glitch-filter, stretch, sticky seen (clk_i/rst_ni; irq_raw_i,seen_clr_i -> intr_src_o,seen_o)
module irq_src_conditioner #(
  parameter int unsigned SOURCE_NUM = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned STRETCH_CYCLES = 0,
  parameter logic [SOURCE_NUM-1:0] INVERT_MASK = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SOURCE_NUM-1:0] irq_raw_i,
  input  logic [SOURCE_NUM-1:0] seen_clr_i,
  output logic [SOURCE_NUM-1:0] intr_src_o,
  output logic [SOURCE_NUM-1:0] seen_o
);
  localparam int unsigned CW = ($clog2(FILTER_CYCLES + 1) < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  logic [SYNC_STAGES-1:0][SOURCE_NUM-1:0] sync_q, sync_d;
  logic [SOURCE_NUM-1:0][CW-1:0] cnt_q, cnt_d;
  logic [SOURCE_NUM-1:0] syn, filt_q, filt_d, rise_q, rise_d, seen_q, seen_d;
  assign syn = sync_q[SYNC_STAGES-1];
  assign seen_o = seen_q;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_raw_i ^ INVERT_MASK};
    filt_d = filt_q;
    cnt_d = '0;
    for (int i = 0; i < SOURCE_NUM; i++) begin
      filt_d[i] = (syn[i] != filt_q[i] && cnt_q[i] == LAST) ? syn[i] : filt_q[i];
      cnt_d[i] = (syn[i] == filt_q[i] || cnt_q[i] == LAST) ? '0 : cnt_q[i] + 1'b1;
    end
    rise_d = filt_d & ~filt_q;
    seen_d = rise_q | (seen_q & ~seen_clr_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= '0;
      cnt_q <= '0;
      rise_q <= '0;
      seen_q <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q <= cnt_d;
      rise_q <= rise_d;
      seen_q <= seen_d;
    end
  if (STRETCH_CYCLES > 0) begin : g_str
    // rise_q marks the load cycle; str then counts the remaining STRETCH_CYCLES-1 cycles
    logic [SOURCE_NUM-1:0][7:0] str_q, str_d;
    logic [SOURCE_NUM-1:0] act;
    always_comb begin
      str_d = str_q;
      act = '0;
      for (int i = 0; i < SOURCE_NUM; i++) begin
        str_d[i] = rise_q[i] ? 8'(STRETCH_CYCLES - 1) : (str_q[i] != 8'd0) ? str_q[i] - 8'd1 : str_q[i];
        act[i] = str_q[i] != 8'd0;
      end
    end
    always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) str_q <= '0;
      else str_q <= str_d;
    assign intr_src_o = filt_q | rise_q | act;
  end else begin : g_nostr
    assign intr_src_o = filt_q;
  end
endmodule

// File: doc/irq_src_conditioner.md
IRQ_SRC_CONDITIONER -- requirements
Module: irq_src_conditioner

Interface
REQ-001 SHALL have parameter SOURCE_NUM, default 32, number of interrupt lines; it matches the PLIC SOURCE_NUM.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; legal range is 2 to 4.
REQ-003 SHALL have parameter FILTER_CYCLES, default 4, number of consecutive stable cycles needed to accept a level change; legal range is 1 to 255.
REQ-004 SHALL have parameter STRETCH_CYCLES, default 0, minimum output high time after an accepted rising edge; 0 disables stretching; legal range is 0 to 255.
REQ-005 SHALL have parameter INVERT_MASK, logic [SOURCE_NUM-1:0], default '0; bit=1 means that raw line is active-low.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-007 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port irq_raw_i, input, SOURCE_NUM bits: raw peripheral interrupt lines, asynchronous to clk_i.
REQ-009 SHALL have port seen_clr_i, input, SOURCE_NUM bits: per-source clear of the sticky seen flag, one-cycle pulse.
REQ-010 SHALL have port intr_src_o, output, SOURCE_NUM bits: conditioned lines; drives PLIC intr_src_i directly.
REQ-011 SHALL have port seen_o, output, SOURCE_NUM bits: sticky flag recording an accepted rising edge.

Function
REQ-012 SHALL, per source, compute in = irq_raw_i[i] XOR INVERT_MASK[i] combinationally before the synchronizer.
REQ-013 SHALL pass in through a SYNC_STAGES-deep flop chain; syn = last stage; no other logic between stages.
REQ-014 SHALL hold per-source state filt (1 bit) and cnt (width $clog2(FILTER_CYCLES+1), minimum 1).
REQ-015 SHALL, each cycle where syn == filt, set cnt <= 0 and keep filt.
REQ-016 SHALL, each cycle where syn != filt and cnt == FILTER_CYCLES-1, set filt <= syn and cnt <= 0.
REQ-017 SHALL, each cycle where syn != filt and cnt < FILTER_CYCLES-1, set cnt <= cnt+1.
REQ-018 SHALL reject a glitch shorter than FILTER_CYCLES cycles at syn: filt is unchanged and cnt returns to 0 when syn matches filt again.
REQ-019 SHALL, for a raw change held stable, make filt reflect it after exactly SYNC_STAGES+FILTER_CYCLES rising edges.
REQ-020 SHALL hold per-source stretch counter str (8 bits).
REQ-021 SHALL load str <= STRETCH_CYCLES-1 in the cycle filt rises (filt 0->1) when STRETCH_CYCLES>0.
REQ-022 SHALL otherwise decrement str while it is nonzero.
REQ-023 SHALL treat a new filt rise during an active stretch as a reload of str.
REQ-024 SHALL drive intr_src_o[i] = filt | (str != 0 or the cycle of load); the output goes high coincident with filt and stays high for at least STRETCH_CYCLES cycles.
REQ-025 SHALL, when STRETCH_CYCLES==0, drive intr_src_o = filt, with no stretch logic inferred.
REQ-026 SHALL set seen_o[i] in the cycle after filt rises.
REQ-027 SHALL clear seen_o[i] in the cycle after seen_clr_i[i]=1.
REQ-028 SHALL give set priority when the set and the clear occur in the same cycle.
REQ-029 SHALL keep sources fully independent; there are no cross-source interactions.
REQ-030 SHALL register intr_src_o with no combinational path from irq_raw_i or seen_clr_i to any output.

Reset
REQ-031 SHALL, on rst_ni=0, asynchronously clear all sync flops, filt, cnt, str and seen: intr_src_o = 0 and seen_o = 0 regardless of INVERT_MASK.
REQ-032 SHALL, on reset deassertion with an active-low line held low, show that source as active only after SYNC_STAGES+FILTER_CYCLES cycles, never earlier.
REQ-033 SHALL, on reset asserted mid-filter or mid-stretch, discard the partial count; no output pulse is emitted after release unless the input re-qualifies.

Verification
REQ-034 SHALL cover: defaults, irq_raw_i[3] 0->1 held -> intr_src_o[3] rises exactly 6 edges later, and seen_o[3] rises 1 cycle after that.
REQ-035 SHALL cover: a 3-cycle high glitch on irq_raw_i[5] (FILTER_CYCLES=4) -> intr_src_o[5] stays 0 and seen_o[5] stays 0.
REQ-036 SHALL cover: INVERT_MASK[0]=1, raw[0] held 1 through reset then driven 0 -> intr_src_o[0] is 0 during reset and rises 6 edges after the 1->0 change.
REQ-037 SHALL cover: STRETCH_CYCLES=8, a raw pulse that qualifies filt high for 1 cycle -> intr_src_o high for exactly 8 cycles.
REQ-038 SHALL cover: seen_clr_i[2] asserted in the same cycle as the seen set for source 2 -> seen_o[2]=1; a clear the following cycle -> seen_o[2]=0.
REQ-039 SHALL cover: rst_ni pulsed low while cnt=2 on source 7 with the input then returned low -> intr_src_o[7] stays 0 after release.
